uart_packet_sink: RTL and testbench

Parametrised UART receiver that assembles `BYTES` consecutive characters into one packet word. It is the next generation of `UartSink` and sits on the host-to-kernel link, driven by `UartSource`-style transmitters. Over the existing sink it adds:
- configurable character width and parity mode;
- input synchronisation and 3-sample majority voting;
- parity and framing error reporting;
- an inter-byte timeout that discards partial packets.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_char_rx.sv | 150 +++++++++++++++
 rtl/uart_packet_sink.sv | 133 +++++++++++++
 tb/tb_uart_packet_sink.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode codes, character-FSM state type and
// the clocks-per-bit helper used to size bit-period counters.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } char_state_t;

  // Core clocks per serial bit (integer division, truncating).
  function automatic int unsigned clks_per_bit(input int unsigned hz, input int unsigned baud);
    return hz / baud;
  endfunction

endpackage

// File: rtl/uart_char_rx.sv
// Single-character UART receiver: 2-FF synchroniser, 3-sample majority vote
// around mid-bit, and the IDLE/START/DATA/PAR/STOP character FSM.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   rx            raw serial input (idle high)
//   char_valid_c  pulse at the stop-bit vote of an accepted character
//   char_data     received data bits (LSB = first bit on the line)
//   char_perr     parity mismatch of the current character
//   char_ferr_c   pulse at the stop-bit vote when the stop bit is 0
//   line_idle     FSM is in IDLE
//   start_edge_c  armed falling edge seen in IDLE
//   start_ok_c    start bit confirmed low at its vote point
module uart_char_rx
  import uart_pkg::*;
#(
  parameter int unsigned CPB    = 434,
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned PARITY = PAR_NONE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              char_valid_c,
  output logic [DWIDTH-1:0] char_data,
  output logic              char_perr,
  output logic              char_ferr_c,
  output logic              line_idle,
  output logic              start_edge_c,
  output logic              start_ok_c
);

  localparam int unsigned CW     = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned BW     = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam int unsigned HALF   = CPB / 2;
  localparam logic        ODD    = (PARITY == PAR_ODD);
  localparam logic        PAR_EN = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);

  logic              rx_meta, rx_sync, rx_prev;
  char_state_t       state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [BW-1:0]     bitn, bitn_d;
  logic              s0, s0_d, s1, s1_d;
  logic [DWIDTH-1:0] shreg, shreg_d;
  logic              perr_bit, perr_d;
  logic              wait_high, wait_d;

  logic fall, vote, vote_pt, bit_end;

  assign fall    = rx_prev & ~rx_sync;
  assign vote    = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);
  assign vote_pt = (cnt == CW'(HALF + 1));
  assign bit_end = (cnt == CW'(CPB - 1));

  assign char_data = shreg;
  assign char_perr = perr_bit;

  // State and datapath registers; synchroniser resets to the idle level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bitn      <= '0;
      s0        <= 1'b1;
      s1        <= 1'b1;
      shreg     <= '0;
      perr_bit  <= 1'b0;
      wait_high <= 1'b0;
      line_idle <= 1'b1;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      state     <= state_d;
      cnt       <= cnt_d;
      bitn      <= bitn_d;
      s0        <= s0_d;
      s1        <= s1_d;
      shreg     <= shreg_d;
      perr_bit  <= perr_d;
      wait_high <= wait_d;
      line_idle <= (state_d == IDLE);
    end
  end

  // Next-state and strobe logic.
  always_comb begin
    state_d      = state;
    cnt_d        = bit_end ? '0 : cnt + CW'(1);
    bitn_d       = bitn;
    s0_d         = (cnt == CW'(HALF - 1)) ? rx_sync : s0;
    s1_d         = (cnt == CW'(HALF)) ? rx_sync : s1;
    shreg_d      = shreg;
    perr_d       = perr_bit;
    wait_d       = wait_high & ~rx_sync;
    char_valid_c = 1'b0;
    char_ferr_c  = 1'b0;
    start_edge_c = 1'b0;
    start_ok_c   = 1'b0;

    case (state)
      IDLE: begin
        cnt_d = '0;
        // After a framing error the line must return high before re-arming.
        if (!wait_high && fall) begin
          state_d      = START;
          start_edge_c = 1'b1;
        end
      end
      START: begin
        if (vote_pt) begin
          if (vote) state_d = IDLE;
          else      start_ok_c = 1'b1;
        end
        if (bit_end) begin
          state_d = DATA;
          bitn_d  = '0;
          perr_d  = 1'b0;
        end
      end
      DATA: begin
        if (vote_pt) shreg_d = {vote, shreg[DWIDTH-1:1]};
        if (bit_end) begin
          if (bitn == BW'(DWIDTH - 1)) state_d = PAR_EN ? PAR : STOP;
          else                         bitn_d  = bitn + BW'(1);
        end
      end
      PAR: begin
        if (vote_pt) perr_d = vote ^ (^shreg) ^ ODD;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // Decide at the vote point so the next start edge is caught early.
        if (vote_pt) begin
          state_d = IDLE;
          if (vote) begin
            char_valid_c = 1'b1;
          end else begin
            char_ferr_c = 1'b1;
            wait_d      = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_packet_sink.sv
// UART packet sink: assembles BYTES received characters into one packet word,
// reporting parity, framing and inter-byte timeout conditions.
// Ports:
//   iCLOCK   clock (rising edge)
//   iNRESET  synchronous active-low reset
//   iRX      asynchronous serial input, idle high
//   oRECEPT  packet in progress
//   oDONE    one-cycle pulse, complete packet on oFDATA
//   oFDATA   last completed packet, first character in the LSB lane
//   oPERR    sticky parity error of the packet, qualified by oDONE
//   oFERR    one-cycle pulse, framing error (packet aborted)
//   oTOUT    one-cycle pulse, inter-byte timeout (packet aborted)
module uart_packet_sink
  import uart_pkg::*;
#(
  parameter int unsigned SCYCLE       = 50000000,
  parameter int unsigned BAUDRATE     = 115200,
  parameter int unsigned DWIDTH       = 8,
  parameter int unsigned BYTES        = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic                    iCLOCK,
  input  logic                    iNRESET,
  input  logic                    iRX,
  output logic                    oRECEPT,
  output logic                    oDONE,
  output logic [BYTES*DWIDTH-1:0] oFDATA,
  output logic                    oPERR,
  output logic                    oFERR,
  output logic                    oTOUT
);

  localparam int unsigned CPB      = clks_per_bit(SCYCLE, BAUDRATE);
  localparam int unsigned FW       = BYTES * DWIDTH;
  localparam int unsigned CNTW     = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned TOUT_CYC = TIMEOUT_BITS * CPB;
  localparam int unsigned IW       = $clog2(TOUT_CYC + 1);

  logic              char_valid_c, char_ferr_c, char_perr;
  logic              line_idle, start_edge_c, start_ok_c;
  logic [DWIDTH-1:0] char_data;

  logic [CNTW-1:0]   byte_cnt;
  logic [FW-1:0]     shadow, shadow_next;
  logic              perr_q;
  logic [IW-1:0]     idle_cnt;
  logic              last_c;

  uart_char_rx #(
    .CPB    (CPB),
    .DWIDTH (DWIDTH),
    .PARITY (PARITY)
  ) u_char_rx (
    .clk          (iCLOCK),
    .rst_n        (iNRESET),
    .rx           (iRX),
    .char_valid_c (char_valid_c),
    .char_data    (char_data),
    .char_perr    (char_perr),
    .char_ferr_c  (char_ferr_c),
    .line_idle    (line_idle),
    .start_edge_c (start_edge_c),
    .start_ok_c   (start_ok_c)
  );

  assign last_c = (byte_cnt == CNTW'(BYTES - 1));

  // Shadow word with the incoming character placed in its lane.
  always_comb begin
    shadow_next = shadow;
    for (int unsigned k = 0; k < BYTES; k++) begin
      if (byte_cnt == CNTW'(k)) shadow_next[k*DWIDTH +: DWIDTH] = char_data;
    end
  end

  // Packet assembly, idle timeout and status pulses.
  always_ff @(posedge iCLOCK) begin
    if (!iNRESET) begin
      oRECEPT  <= 1'b0;
      oDONE    <= 1'b0;
      oFDATA   <= '0;
      oPERR    <= 1'b0;
      oFERR    <= 1'b0;
      oTOUT    <= 1'b0;
      byte_cnt <= '0;
      shadow   <= '0;
      perr_q   <= 1'b0;
      idle_cnt <= '0;
    end else begin
      oDONE <= 1'b0;
      oPERR <= 1'b0;
      oFERR <= 1'b0;
      oTOUT <= 1'b0;

      if (start_ok_c) oRECEPT <= 1'b1;

      if (char_ferr_c) begin
        oFERR    <= 1'b1;
        oRECEPT  <= 1'b0;
        byte_cnt <= '0;
        perr_q   <= 1'b0;
      end else if (char_valid_c) begin
        shadow <= shadow_next;
        if (last_c) begin
          oDONE    <= 1'b1;
          oPERR    <= perr_q | char_perr;
          oFDATA   <= shadow_next;
          oRECEPT  <= 1'b0;
          byte_cnt <= '0;
          perr_q   <= 1'b0;
        end else begin
          byte_cnt <= byte_cnt + CNTW'(1);
          perr_q   <= perr_q | char_perr;
        end
      end

      // A start edge on the threshold cycle wins over the timeout.
      if (byte_cnt == '0 || !line_idle || start_edge_c) begin
        idle_cnt <= '0;
      end else if (idle_cnt == IW'(TOUT_CYC - 1)) begin
        oTOUT    <= 1'b1;
        oRECEPT  <= 1'b0;
        byte_cnt <= '0;
        perr_q   <= 1'b0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_packet_sink.sv
// Scoreboard bench for uart_packet_sink. Two instances share clock and reset:
// dut0 without parity and dut2 with even parity. The line rate is raised to
// give 16 clocks per bit so every scenario fits a short run; the glitch is
// scaled to 5 clocks, well under half a bit.
module tb_uart_packet_sink;

  localparam int unsigned SCYCLE = 50_000_000;
  localparam int unsigned BAUD   = 3_125_000;
  localparam int unsigned CPB    = 16;

  localparam logic [1:0] K_DONE = 2'd0;
  localparam logic [1:0] K_FERR = 2'd1;
  localparam logic [1:0] K_TOUT = 2'd2;

  localparam logic [63:0] P1 = 64'hB1B0_AFAE_ADAC_ABAA;
  localparam logic [63:0] P2 = 64'hEFCD_AB89_6745_2301;

  typedef struct packed {
    logic [1:0]  kind;
    logic [63:0] data;
    logic        perr;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx0   = 1'b1;
  logic        rx2   = 1'b1;

  logic        recept0, done0, perr0, ferr0, tout0;
  logic [63:0] fdata0;
  logic        recept2, done2, perr2, ferr2, tout2;
  logic [63:0] fdata2;

  exp_t        q0[$];
  exp_t        q2[$];
  logic [63:0] exp_fd0 = '0;
  logic [63:0] exp_fd2 = '0;

  int checks = 0;
  int errors = 0;

  uart_packet_sink #(
    .SCYCLE(SCYCLE), .BAUDRATE(BAUD), .DWIDTH(8), .BYTES(8), .PARITY(0), .TIMEOUT_BITS(32)
  ) dut0 (
    .iCLOCK(clk), .iNRESET(rst_n), .iRX(rx0), .oRECEPT(recept0), .oDONE(done0),
    .oFDATA(fdata0), .oPERR(perr0), .oFERR(ferr0), .oTOUT(tout0)
  );

  uart_packet_sink #(
    .SCYCLE(SCYCLE), .BAUDRATE(BAUD), .DWIDTH(8), .BYTES(8), .PARITY(2), .TIMEOUT_BITS(32)
  ) dut2 (
    .iCLOCK(clk), .iNRESET(rst_n), .iRX(rx2), .oRECEPT(recept2), .oDONE(done2),
    .oFDATA(fdata2), .oPERR(perr2), .oFERR(ferr2), .oTOUT(tout2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input int ln, input logic [1:0] kind, input logic [63:0] data, input logic perr);
    exp_t e;
    e.kind = kind;
    e.perr = perr;
    if (ln == 0) begin
      if (kind == K_DONE) exp_fd0 = data;
      e.data = exp_fd0;
      q0.push_back(e);
    end else begin
      if (kind == K_DONE) exp_fd2 = data;
      e.data = exp_fd2;
      q2.push_back(e);
    end
  endtask

  task automatic drive(input int ln, input logic v);
    if (ln == 0) rx0 = v;
    else         rx2 = v;
  endtask

  task automatic idle(input int unsigned bits);
    repeat (bits * CPB) @(negedge clk);
  endtask

  task automatic send_char(input int ln, input logic [7:0] d, input bit par_en,
                           input bit par_inv, input logic stop_v);
    drive(ln, 1'b0);
    idle(1);
    for (int i = 0; i < 8; i++) begin
      drive(ln, d[i]);
      idle(1);
    end
    if (par_en) begin
      drive(ln, (^d) ^ par_inv);
      idle(1);
    end
    drive(ln, stop_v);
    idle(1);
    drive(ln, 1'b1);
  endtask

  task automatic send_packet(input int ln, input logic [63:0] pkt, input bit par_en,
                             input int bad_par, input int gap_after, input int gap);
    for (int k = 0; k < 8; k++) begin
      send_char(ln, pkt[k*8 +: 8], par_en, (k == bad_par), 1'b1);
      if (k == gap_after) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_recept"}, 64'(recept0), 64'd0);
    check({tag, "_done"},   64'(done0),   64'd0);
    check({tag, "_fdata"},  fdata0,       64'd0);
    check({tag, "_perr"},   64'(perr0),   64'd0);
    check({tag, "_ferr"},   64'(ferr0),   64'd0);
    check({tag, "_tout"},   64'(tout0),   64'd0);
    check({tag, "_fdata2"}, fdata2,       64'd0);
  endtask

  // Monitor: every status pulse pops one expected event and is compared.
  task automatic mon(input int ln, input logic done, input logic ferr, input logic tout,
                     input logic [63:0] fd, input logic perr, input logic recept);
    exp_t       e;
    logic [1:0] k;
    bit         empty;
    if (!(done | ferr | tout)) return;
    k     = done ? K_DONE : (ferr ? K_FERR : K_TOUT);
    empty = (ln == 0) ? (q0.size() == 0) : (q2.size() == 0);
    if (empty) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event dut%0d actual kind=%0d required none", ln, k);
      return;
    end
    if (ln == 0) e = q0.pop_front();
    else         e = q2.pop_front();
    check($sformatf("dut%0d_kind", ln),   64'(k),      64'(e.kind));
    check($sformatf("dut%0d_fdata", ln),  fd,          e.data);
    check($sformatf("dut%0d_perr", ln),   64'(perr),   64'(e.perr));
    check($sformatf("dut%0d_recept", ln), 64'(recept), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, done0, ferr0, tout0, fdata0, perr0, recept0);
      mon(2, done2, ferr2, tout2, fdata2, perr2, recept2);
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        seen;
    logic [63:0] pkt;

    repeat (3) @(negedge clk);
    check_reset("init");
    rst_n = 1'b1;
    idle(4);

    // Two back-to-back packets; a sub-threshold gap after byte 3 of the first.
    push(0, K_DONE, P1, 1'b0);
    push(0, K_DONE, P2, 1'b0);
    send_packet(0, P1, 1'b0, -1, 3, 400);
    send_packet(0, P2, 1'b0, -1, -1, 0);
    idle(4);

    // Short low glitch: rejected at the start-bit vote.
    seen = 1'b0;
    rx0  = 1'b0;
    repeat (5) @(negedge clk);
    rx0 = 1'b1;
    repeat (3 * CPB) begin
      @(negedge clk);
      seen |= recept0;
    end
    check("glitch_recept", 64'(seen), 64'd0);

    // Framing error on byte 2 aborts the packet; next clean packet intact.
    push(0, K_FERR, '0, 1'b0);
    send_char(0, 8'hAA, 1'b0, 1'b0, 1'b1);
    send_char(0, 8'hAB, 1'b0, 1'b0, 1'b1);
    send_char(0, 8'hAC, 1'b0, 1'b0, 1'b0);
    idle(2);
    push(0, K_DONE, P1, 1'b0);
    send_packet(0, P1, 1'b0, -1, -1, 0);
    idle(2);

    // Three bytes then silence past 32 bit-times.
    push(0, K_TOUT, '0, 1'b0);
    send_char(0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_char(0, 8'h22, 1'b0, 1'b0, 1'b1);
    send_char(0, 8'h33, 1'b0, 1'b0, 1'b1);
    idle(40);
    check("tout_recept_after", 64'(recept0), 64'd0);

    // Even parity: byte 3 with inverted parity, then a clean packet.
    push(2, K_DONE, P1, 1'b1);
    send_packet(2, P1, 1'b1, 3, -1, 0);
    push(2, K_DONE, P2, 1'b0);
    send_packet(2, P2, 1'b1, -1, -1, 0);
    idle(2);

    // Reset during byte 5 (0xAE), taken while the line sits at a 1 data bit.
    pkt = P1;
    for (int k = 0; k < 4; k++) send_char(0, pkt[k*8 +: 8], 1'b0, 1'b0, 1'b1);
    rx0 = 1'b0;
    idle(1);
    rx0 = pkt[32];
    idle(1);
    rx0 = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    check("recept_mid_packet", 64'(recept0), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("mid_reset");
    rst_n   = 1'b1;
    exp_fd0 = '0;
    exp_fd2 = '0;
    idle(12);
    push(0, K_DONE, P2, 1'b0);
    send_packet(0, P2, 1'b0, -1, -1, 0);
    idle(4);

    check("pending_dut0", 64'(q0.size()), 64'd0);
    check("pending_dut2", 64'(q2.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
